shift_ram_tile_ctrl: RTL and testbench
======================================

// Module: shift_ram_tile_ctrl
// PURPOSE
//  Sequencer for one dilated_shift_ram instance over one TILE_H x TILE_W ifmap tile.
//  Clears the line buffer, pulls pixels from the ifmap FIFO and drives the shift enable.
//  Tracks the raster position and flags each cycle where the tap outputs hold a complete,
//  in-tile 3x3 window for the selected dilation. Sits between tile scheduler and PE array.
// PARAMETERS
//  TILE_W  32  tile width in pixels
//  TILE_H  32  tile height in pixels
//  POS_W   6   width of row/col counters and coordinate outputs; must hold max(TILE_W,TILE_H)
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous reset, active-high
//  start_i         in   1      start one tile; sampled only in IDLE
//  abort_i         in   1      abandon current tile
//  dilation_sel_i  in   2      00 none (D=1), 01 D=2, 10 D=4, 11 illegal; sampled with start_i
//  pe_ready_i      in   1      downstream can take a window this cycle
//  fifo_valid_i    in   1      ifmap FIFO has a pixel
//  fifo_req_o      out  1      pop request to ifmap FIFO
//  sr_en_o         out  1      shift enable to dilated_shift_ram
//  sr_clear_o      out  1      clear to dilated_shift_ram
//  sr_dilation_o   out  2      latched dilation code to dilated_shift_ram
//  win_valid_o     out  1      tap outputs hold a valid window this cycle
//  win_row_o       out  POS_W  window centre row
//  win_col_o       out  POS_W  window centre column
//  busy_o          out  1      not IDLE
//  done_o          out  1      one-cycle pulse: tile fully consumed
//  err_o           out  1      one-cycle pulse: start_i with dilation_sel_i==11
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row/col counters 0; latched dilation 00.
//  States: IDLE, CLEAR, RUN, DONE.
//   IDLE : start_i & code!=11 -> latch code, CLEAR. start_i & code==11 -> err_o next cycle, stay IDLE.
//   CLEAR: sr_clear_o=1 for exactly one cycle; row=col=0 -> RUN (or IDLE if entered via abort).
//   RUN  : fifo_req_o=pe_ready_i; accept = fifo_valid_i & pe_ready_i; sr_en_o=accept (comb).
//          Each accept advances col; col==TILE_W-1 wraps to 0 and increments row.
//          Accept at (TILE_H-1,TILE_W-1) -> DONE.
//   DONE : done_o=1 for one cycle -> IDLE.
//  abort_i (CLEAR/RUN/DONE): next state CLEAR with abort flag, then IDLE; no done_o.
//   abort_i has priority over start/accept in the same cycle; ignored in IDLE.
//  start_i outside IDLE ignored; dilation_sel_i changes outside IDLE ignored.
//  D from latched code: 00->1, 01->2, 10->4. sr_dilation_o = latched code, stable for whole tile.
//  Window: accept at (r,c) with r>=2D and c>=2D -> registered win_valid_o=1 the next cycle,
//   win_row_o=r-D, win_col_o=c-D (latency 1, aligned with registered taps). Else win_valid_o=0.
//  Rows of the line buffer are one pixel apart per tap at D=1 (tile width is handled upstream);
//   no windows straddle a row wrap: the c>=2D check suppresses them.
//  Windows per tile = (TILE_H-2D)*(TILE_W-2D); 900 at D=1, 32x32.
//  FIFO stall (fifo_valid_i=0) or pe_ready_i=0: counters hold, sr_en_o=0, win_valid_o=0 next.
//  rst mid-tile: immediate return to reset values; no sr_clear_o issued (shift RAM reset separately).
//  Counters never exceed TILE-1; no wrap beyond tile end.
// STRUCTURE
//  Shared package cnn_pkg: DILATION_NONE/2/4 codes (2'b00/01/10), TILE_W/TILE_H defaults.
//  State encoding local to this module.
//  One sub-module: tile_pos_counter (row/col raster counter with inc, clr, last flag).
// TESTING
//  D=1, fifo always valid, pe_ready=1 -> clear 1 cycle, 1024 sr_en, 900 windows, first at (1,1), done after last.
//  D=2 then D=4 back-to-back tiles -> 784 windows first (2,2); 576 windows first (4,4); sr_dilation_o tracks code.
//  fifo_valid toggling 1/0 every cycle, D=1 -> same 900 windows/coords, 2048+ cycles, no sr_en when invalid.
//  abort_i at pixel 500 -> one sr_clear_o pulse, IDLE, no done_o; next start gives full 900 windows.
//  start_i with code 11 -> err_o pulse, busy_o stays 0; start_i during RUN -> ignored, tile unaffected.
//  rst asserted at pixel 300 -> all outputs 0 next cycle, state IDLE, counters 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: dilation codes, tile defaults and the
// code-to-dilation-factor mapping used by the shift-RAM sequencers.
package cnn_pkg;

    localparam logic [1:0] DILATION_NONE = 2'b00;
    localparam logic [1:0] DILATION_2    = 2'b01;
    localparam logic [1:0] DILATION_4    = 2'b10;
    localparam logic [1:0] DILATION_BAD  = 2'b11;

    localparam int TILE_W_DEF = 32;
    localparam int TILE_H_DEF = 32;

    function automatic logic [2:0] dil_factor(input logic [1:0] code);
        logic [2:0] d;
        case (code)
            DILATION_2: d = 3'd2;
            DILATION_4: d = 3'd4;
            default:    d = 3'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Raster row/column counter for one tile; saturates at the last pixel so it
// never runs past the tile end.
module tile_pos_counter
    import cnn_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int TILE_H = TILE_H_DEF,
    parameter int POS_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [POS_W-1:0] row_o,
    output logic [POS_W-1:0] col_o,
    output logic             last_o
);

    logic [POS_W-1:0] row_reg, row_next;
    logic [POS_W-1:0] col_reg, col_next;
    logic             col_last;
    logic             row_last;

    assign col_last = (col_reg == POS_W'(TILE_W - 1));
    assign row_last = (row_reg == POS_W'(TILE_H - 1));
    assign last_o   = col_last && row_last;
    assign row_o    = row_reg;
    assign col_o    = col_reg;

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clr) begin
            row_next = '0;
            col_next = '0;
        end else if (inc && !last_o) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

endmodule

// File: rtl/shift_ram_tile_ctrl.sv
// Tile sequencer for a dilated shift RAM: clears the line buffer, streams one
// tile of pixels from the ifmap FIFO and flags complete in-tile 3x3 windows.
module shift_ram_tile_ctrl
    import cnn_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int TILE_H = TILE_H_DEF,
    parameter int POS_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       dilation_sel_i,
    input  logic             pe_ready_i,
    input  logic             fifo_valid_i,
    output logic             fifo_req_o,
    output logic             sr_en_o,
    output logic             sr_clear_o,
    output logic [1:0]       sr_dilation_o,
    output logic             win_valid_o,
    output logic [POS_W-1:0] win_row_o,
    output logic [POS_W-1:0] win_col_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       dilation_reg, dilation_next;
    logic             abort_flag_reg, abort_flag_next;
    logic             err_reg, err_next;
    logic             win_valid_reg, win_valid_next;
    logic [POS_W-1:0] win_row_reg, win_row_next;
    logic [POS_W-1:0] win_col_reg, win_col_next;

    logic             accept;
    logic             cnt_clr;
    logic [POS_W-1:0] pos_row;
    logic [POS_W-1:0] pos_col;
    logic             pos_last;
    logic [POS_W-1:0] d_val;
    logic [POS_W-1:0] two_d;

    tile_pos_counter #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .POS_W  (POS_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (accept),
        .row_o  (pos_row),
        .col_o  (pos_col),
        .last_o (pos_last)
    );

    assign d_val = POS_W'(dil_factor(dilation_reg));
    assign two_d = d_val << 1;

    // abort wins over accept, so no pixel is consumed in the abort cycle
    always_comb begin
        state_next      = state_reg;
        dilation_next   = dilation_reg;
        abort_flag_next = abort_flag_reg;
        err_next        = 1'b0;
        accept          = 1'b0;
        cnt_clr         = 1'b0;
        fifo_req_o      = 1'b0;
        sr_clear_o      = 1'b0;
        done_o          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    if (dilation_sel_i == DILATION_BAD) begin
                        err_next = 1'b1;
                    end else begin
                        dilation_next   = dilation_sel_i;
                        abort_flag_next = 1'b0;
                        state_next      = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                sr_clear_o = 1'b1;
                cnt_clr    = 1'b1;
                if (abort_i) begin
                    abort_flag_next = 1'b1;
                end else begin
                    state_next      = abort_flag_reg ? ST_IDLE : ST_RUN;
                    abort_flag_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    abort_flag_next = 1'b1;
                    state_next      = ST_CLEAR;
                end else begin
                    fifo_req_o = pe_ready_i;
                    accept     = fifo_valid_i && pe_ready_i;
                    if (accept && pos_last) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort_i) begin
                    abort_flag_next = 1'b1;
                    state_next      = ST_CLEAR;
                end else begin
                    done_o     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // window centre lags the newest pixel by D in both directions
    always_comb begin
        win_valid_next = accept && (pos_row >= two_d) && (pos_col >= two_d);
        win_row_next   = win_row_reg;
        win_col_next   = win_col_reg;
        if (win_valid_next) begin
            win_row_next = pos_row - d_val;
            win_col_next = pos_col - d_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            dilation_reg   <= DILATION_NONE;
            abort_flag_reg <= 1'b0;
            err_reg        <= 1'b0;
            win_valid_reg  <= 1'b0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            dilation_reg   <= dilation_next;
            abort_flag_reg <= abort_flag_next;
            err_reg        <= err_next;
            win_valid_reg  <= win_valid_next;
            win_row_reg    <= win_row_next;
            win_col_reg    <= win_col_next;
        end
    end

    assign sr_en_o       = accept;
    assign sr_dilation_o = dilation_reg;
    assign win_valid_o   = win_valid_reg;
    assign win_row_o     = win_row_reg;
    assign win_col_o     = win_col_reg;
    assign busy_o        = (state_reg != ST_IDLE);
    assign err_o         = err_reg;

endmodule

// File: tb/tb_shift_ram_tile_ctrl.sv
// Scoreboard bench for shift_ram_tile_ctrl: stimulus queues expected window
// centres, a negedge monitor pops and compares them and tallies pulses.
module tb_shift_ram_tile_ctrl;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          abort_i;
    logic [1:0]    dilation_sel_i;
    logic          pe_ready_i;
    logic          fifo_valid_i;
    logic          fifo_req_o;
    logic          sr_en_o;
    logic          sr_clear_o;
    logic [1:0]    sr_dilation_o;
    logic          win_valid_o;
    logic [PW-1:0] win_row_o;
    logic [PW-1:0] win_col_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    shift_ram_tile_ctrl #(.TILE_W(W), .TILE_H(H), .POS_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .dilation_sel_i (dilation_sel_i),
        .pe_ready_i     (pe_ready_i),
        .fifo_valid_i   (fifo_valid_i),
        .fifo_req_o     (fifo_req_o),
        .sr_en_o        (sr_en_o),
        .sr_clear_o     (sr_clear_o),
        .sr_dilation_o  (sr_dilation_o),
        .win_valid_o    (win_valid_o),
        .win_row_o      (win_row_o),
        .win_col_o      (win_col_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         exp_q[$];
    int         n_en, n_clear, n_done, n_err, n_win, viol;
    int         first_r, first_c;
    int         mon_e;
    logic [1:0] exp_dil = 2'b00;

    always @(negedge clk) begin
        if (sr_en_o) n_en++;
        if (sr_clear_o) n_clear++;
        if (done_o) n_done++;
        if (err_o) n_err++;
        if (sr_en_o && !(fifo_valid_i && pe_ready_i)) viol++;
        if (busy_o && (sr_dilation_o != exp_dil)) viol++;
        if (win_valid_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL win_unexpected: got (%0d,%0d), required no window", win_row_o, win_col_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ((int'(win_row_o) != mon_e / 64) || (int'(win_col_o) != mon_e % 64)) begin
                    fails++;
                    $display("FAIL win_coord: got (%0d,%0d), required (%0d,%0d)",
                             win_row_o, win_col_o, mon_e / 64, mon_e % 64);
                end
                if (n_win == 0) begin
                    first_r = int'(win_row_o);
                    first_c = int'(win_col_o);
                end
                n_win++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_en = 0; n_clear = 0; n_done = 0; n_err = 0; n_win = 0; viol = 0;
        first_r = -1; first_c = -1;
        exp_q.delete();
    endtask

    function automatic int dil_of(input logic [1:0] code);
        return (code == 2'b01) ? 2 : (code == 2'b10) ? 4 : 1;
    endfunction

    task automatic push_windows(input int d, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            if ((idx / W >= 2 * d) && (idx % W >= 2 * d))
                exp_q.push_back((idx / W - d) * 64 + (idx % W - d));
        end
    endtask

    task automatic start_tile(input logic [1:0] code);
        exp_dil        = code;
        start_i        = 1'b1;
        dilation_sel_i = code;
        tick();
        start_i        = 1'b0;
        dilation_sel_i = 2'b11;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ctrl"}, {fifo_req_o, sr_en_o, sr_clear_o, done_o, err_o}, 0);
        check({tag, "_win"}, {win_valid_o, win_row_o, win_col_o}, 0);
        check({tag, "_dil"}, sr_dilation_o, 0);
    endtask

    task automatic run_tile(input logic [1:0] code, input bit toggle, input bit inject_start,
                            input string name, input int exp_win);
        int  d;
        int  cyc;
        bit  done_seen;
        d = dil_of(code);
        clear_counts();
        push_windows(d, W * H);
        start_tile(code);
        cyc       = 0;
        done_seen = 0;
        while (cyc < 5000 && !done_seen) begin
            fifo_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
            if (inject_start && cyc == 100) begin
                start_i        = 1'b1;
                dilation_sel_i = (code == 2'b00) ? 2'b01 : 2'b00;
            end else begin
                start_i = 1'b0;
            end
            tick();
            cyc++;
            if (cyc == 10) check({name, "_dil_latched"}, sr_dilation_o, code);
            if (done_o) done_seen = 1;
        end
        start_i      = 1'b0;
        fifo_valid_i = 1'b0;
        tick();
        tick();
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_sr_en"}, n_en, W * H);
        check({name, "_clear"}, n_clear, 1);
        check({name, "_done"}, n_done, 1);
        check({name, "_windows"}, n_win, exp_win);
        check({name, "_first_r"}, first_r, d);
        check({name, "_first_c"}, first_c, d);
        check({name, "_q_left"}, exp_q.size(), 0);
        check({name, "_viol"}, viol, 0);
        check({name, "_busy"}, busy_o, 0);
        if (toggle) check({name, "_cycles_ge_2048"}, int'(cyc >= 2048), 1);
        $display("[TB] tile %s: D=%0d sr_en=%0d windows=%0d cycles=%0d", name, d, n_en, n_win, cyc);
        exp_q.delete();
    endtask

    task automatic interrupted_tile(input bit use_rst, input int npix, input string name,
                                    input int exp_win);
        int cyc;
        int clr_before;
        clear_counts();
        push_windows(1, npix);
        start_tile(2'b00);
        fifo_valid_i = 1'b1;
        cyc = 0;
        while (cyc < 3000 && n_en < npix) begin
            tick();
            cyc++;
        end
        check({name, "_reached"}, n_en, npix);
        clr_before = n_clear;
        if (use_rst) begin
            rst          = 1'b1;
            fifo_valid_i = 1'b0;
            tick();
            rst = 1'b0;
            check_idle_outputs({name, "_post"});
        end else begin
            abort_i = 1'b1;
            tick();
            abort_i = 1'b0;
        end
        tick();
        tick();
        tick();
        fifo_valid_i = 1'b0;
        check({name, "_clear_pulses"}, n_clear - clr_before, use_rst ? 0 : 1);
        check({name, "_no_done"}, n_done, 0);
        check({name, "_busy"}, busy_o, 0);
        check({name, "_sr_en"}, n_en, npix);
        check({name, "_windows"}, n_win, exp_win);
        check({name, "_q_left"}, exp_q.size(), 0);
        check({name, "_viol"}, viol, 0);
        $display("[TB] tile %s: stopped after %0d pixels, windows=%0d", name, n_en, n_win);
        exp_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        start_i        = 1'b0;
        abort_i        = 1'b0;
        dilation_sel_i = 2'b00;
        pe_ready_i     = 1'b1;
        fifo_valid_i   = 1'b0;
        clear_counts();
        tick();
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        tick();

        // illegal dilation code: one err pulse, never busy
        clear_counts();
        start_i        = 1'b1;
        dilation_sel_i = 2'b11;
        tick();
        start_i        = 1'b0;
        dilation_sel_i = 2'b00;
        check("err_pulse", err_o, 1);
        check("err_busy", busy_o, 0);
        tick();
        check("err_pulse_end", err_o, 0);
        check("err_busy2", busy_o, 0);
        tick();
        check("err_count", n_err, 1);
        check("err_no_clear", n_clear, 0);
        $display("[TB] err test: err pulses=%0d", n_err);

        run_tile(2'b00, 1'b0, 1'b0, "d1", 900);
        run_tile(2'b01, 1'b0, 1'b0, "d2", 784);
        run_tile(2'b10, 1'b0, 1'b0, "d4", 576);
        run_tile(2'b00, 1'b1, 1'b0, "d1_toggle", 900);
        run_tile(2'b00, 1'b0, 1'b1, "d1_start_in_run", 900);

        // 500 pixels in: rows 2..14 (13*30) + row 15 cols 2..19 (18) = 408
        interrupted_tile(1'b0, 500, "abort500", 408);
        run_tile(2'b00, 1'b0, 1'b0, "d1_after_abort", 900);

        // 300 pixels in: rows 2..8 (7*30) + row 9 cols 2..11 (10) = 220
        interrupted_tile(1'b1, 300, "rst300", 220);
        run_tile(2'b00, 1'b0, 1'b0, "d1_after_rst", 900);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
